poly_delay_addsub: RTL and testbench

//  Coefficient-wise add/subtract mod q of two NewHope polynomials. Operand A comes from the current stage's BRAM;

---
 rtl/poly_delay_addsub.sv | 150 +++++++++++++++
 tb/tb_poly_delay_addsub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_delay_addsub.sv
// Coefficient-wise (a +/- b) mod Q over one NewHope polynomial, streaming from
// the stage BRAM and delay RAM into the next-stage BRAM, then pulsing a ring shift.
module poly_delay_addsub #(
    parameter int N  = 512,
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int Q  = 12289
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    output logic          busy,
    output logic          done,
    output logic          shift_out,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] a_di,
    input  logic [DW-1:0] b_di,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam logic [1:0]    IDLE  = 2'd0;
    localparam logic [1:0]    READ  = 2'd1;
    localparam logic [1:0]    DRAIN = 2'd2;
    localparam logic [1:0]    FIN   = 2'd3;
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [14:0]   Q15   = 15'(Q);

    // Single conditional subtraction suffices because both operands are below Q.
    function automatic logic [DW-1:0] mod_addsub(input logic sub,
                                                 input logic [13:0] a,
                                                 input logic [13:0] b);
        logic [14:0] t;
        if (sub) begin
            t = {1'b0, a} + Q15 - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, b};
        end
        if (t >= Q15) begin
            t = t - Q15;
        end else begin
            t = t;
        end
        return DW'(t);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          op_q, op_d;
    logic          drain_q, drain_d;
    logic          v1_q, v1_d;
    logic [AW-1:0] a1_q, a1_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Control FSM next-state and read address sequencing.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        op_d      = op_q;
        drain_d   = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                    op_d      = op;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_addr_q == LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = FIN;
                end else begin
                    drain_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // Two-stage datapath: address stage tracks BRAM latency, second stage registers the result.
    always_comb begin
        v1_d    = (state_q == READ);
        a1_d    = rd_addr_q;
        wr_en_d = v1_q;
        if (v1_q) begin
            wr_addr_d = a1_q;
            wr_data_d = mod_addsub(op_q, a_di[13:0], b_di[13:0]);
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State and output registers; reset clears everything including any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            op_q      <= 1'b0;
            drain_q   <= 1'b0;
            v1_q      <= 1'b0;
            a1_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            op_q      <= op_d;
            drain_q   <= drain_d;
            v1_q      <= v1_d;
            a1_q      <= a1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_out = done_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_poly_delay_addsub.sv
// Bench for poly_delay_addsub: BRAM models feed a/b, a monitor records the write
// stream and pulses, and each run is checked against a plain mod-Q reference.
module tb_poly_delay_addsub;
    localparam int N  = 512;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int Q  = 12289;

    logic          clk = 1'b0;
    logic          rst_n, start, op;
    logic          busy, done, shift_out, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] a_di, b_di, wr_data;

    poly_delay_addsub #(.N(N), .AW(AW), .DW(DW), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .busy(busy), .done(done), .shift_out(shift_out), .rd_addr(rd_addr),
        .a_di(a_di), .b_di(b_di), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    logic [DW-1:0] out_mem [N];

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        a_di <= mem_a[rd_addr];
        b_di <= mem_b[rd_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int            wr_total = 0, done_total = 0, shift_total = 0;
    int            order_bad = 0, shift_not_done = 0;
    int            first_wr_edge = 0, last_wr_edge = 0, done_edge = 0;
    logic          prev_wr_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Write-stream monitor: bursts must start at 0 and step by one.
    always @(negedge clk) begin
        if (wr_en) begin
            if ((!prev_wr_en && wr_addr != '0) || (prev_wr_en && wr_addr != prev_addr + AW'(1)))
                order_bad <= order_bad + 1;
            if (!prev_wr_en) first_wr_edge <= edge_cnt;
            last_wr_edge     <= edge_cnt;
            out_mem[wr_addr] <= wr_data;
            wr_total         <= wr_total + 1;
        end
        if (done) begin
            done_total <= done_total + 1;
            done_edge  <= edge_cnt;
        end
        if (shift_out) shift_total <= shift_total + 1;
        if (shift_out != done) shift_not_done <= shift_not_done + 1;
        prev_wr_en <= wr_en;
        prev_addr  <= wr_addr;
    end

    int checks = 0, errors = 0;
    int e0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_r(input bit sub, input int a, input int b);
        if (sub) return ((a - b) % Q + Q) % Q;
        else     return (a + b) % Q;
    endfunction

    // One full transaction with optional stray starts mid-run and/or in the FIN cycle.
    task automatic run(input bit op_i, input int extra1, input int extra2, input bit fin_start);
        int  w0, d0, s0, o0, cyc;
        bit  seen;
        @(negedge clk); #1;
        w0 = wr_total; d0 = done_total; s0 = shift_total; o0 = order_bad;
        start = 1'b1; op = op_i; e0 = edge_cnt;
        seen = 1'b0;
        for (int c = 0; c < 700 && !seen; c++) begin
            @(negedge clk); #1;
            cyc   = edge_cnt - e0 - 1;
            start = 1'b0;
            if ((extra1 > 0 && cyc == extra1) || (extra2 > 0 && cyc == extra2)) begin
                start = 1'b1;
                op    = ~op;
            end
            if (cyc == 0) chk("busy_first_cycle", int'(busy), 1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("busy_in_done", int'(busy), 1);
        chk("shift_with_done", int'(shift_out), 1);
        chk("write_count", wr_total - w0, N);
        chk("write_order", order_bad - o0, 0);
        chk("first_wr_latency", first_wr_edge - e0 - 1, 2);
        chk("last_wr_latency", last_wr_edge - e0 - 1, N + 1);
        chk("done_latency", done_edge - e0 - 1, N + 2);
        chk("done_count", done_total - d0, 1);
        chk("shift_count", shift_total - s0, 1);
        chk("shift_eq_done", shift_not_done, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("data[%0d]", k), int'(out_mem[k]), ref_r(op_i, int'(mem_a[k]), int'(mem_b[k])));
        if (fin_start) begin
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            @(negedge clk); #1;
            chk("fin_start_ignored", int'(busy), 0);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            mem_a[k] = DW'($urandom_range(0, Q - 1));
            mem_b[k] = DW'($urandom_range(0, Q - 1));
        end
    endtask

    typedef struct {
        bit sub;
        int idx;
        int a;
        int b;
        int exp;
    } vec_t;
    vec_t tv [9];

    initial begin
        int s0, d0;
        tv[0] = '{1'b0, 0,   12288, 12288, 12287};
        tv[1] = '{1'b0, 1,   4096,  8192,  12288};
        tv[2] = '{1'b0, 2,   4097,  8194,  2};
        tv[3] = '{1'b0, 3,   0,     0,     0};
        tv[4] = '{1'b0, 511, 511,   1022,  1533};
        tv[5] = '{1'b1, 0,   0,     1,     12288};
        tv[6] = '{1'b1, 1,   5,     5,     0};
        tv[7] = '{1'b1, 2,   12288, 0,     12288};
        tv[8] = '{1'b1, 511, 0,     12288, 1};

        rst_n = 1'b0; start = 1'b0; op = 1'b0;
        fill_random();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_shift", int'(shift_out), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rst_n = 1'b1;

        // a[k]=k, b[k]=2k
        for (int k = 0; k < N; k++) begin
            mem_a[k] = DW'(k);
            mem_b[k] = DW'(2 * k);
        end
        run(1'b0, 0, 0, 1'b0);
        chk("ramp_511", int'(out_mem[511]), 1533);

        // Corner vectors embedded in otherwise random polynomials, one run per op.
        for (int o = 0; o < 2; o++) begin
            fill_random();
            for (int i = 0; i < 9; i++)
                if (int'(tv[i].sub) == o) begin
                    mem_a[tv[i].idx] = DW'(tv[i].a);
                    mem_b[tv[i].idx] = DW'(tv[i].b);
                end
            run(o[0], 0, 0, 1'b0);
            for (int i = 0; i < 9; i++)
                if (int'(tv[i].sub) == o)
                    chk($sformatf("vec%0d", i), int'(out_mem[tv[i].idx]), tv[i].exp);
        end

        // Stray starts mid-run with toggled op must not re-latch.
        fill_random();
        run(1'b1, 10, 300, 1'b0);

        // Back-to-back: second start in the cycle right after done.
        fill_random();
        run(1'b0, 0, 0, 1'b0);
        run(1'b0, 0, 0, 1'b0);

        // Start raised during the FIN cycle is ignored.
        fill_random();
        run(1'b1, 0, 0, 1'b1);

        // Reset mid-READ: outputs drop at once, no shift afterwards.
        @(negedge clk); #1;
        start = 1'b1; op = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        s0 = shift_total; d0 = done_total;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_shift", int'(shift_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        #1;
        chk("post_rst_shift", shift_total - s0, 0);
        chk("post_rst_done", done_total - d0, 0);
        chk("post_rst_busy", int'(busy), 0);

        fill_random();
        run(1'b1, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
